// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op encodings and the per-bit result function shared by the logic unit and the ALU decoder checks
package logic_unit_pkg;
  typedef logic [2:0] op_t;
  localparam op_t OP_AND    = 3'b000;
  localparam op_t OP_OR     = 3'b001;
  localparam op_t OP_XOR    = 3'b010;
  localparam op_t OP_NOR    = 3'b011;
  localparam op_t OP_ANDN   = 3'b100;
  localparam op_t OP_ORN    = 3'b101;
  localparam op_t OP_PASS_A = 3'b110;
  localparam op_t OP_PASS_B = 3'b111;
  function automatic logic lu_compute_bit(op_t op, logic a, logic b);
    return op == OP_AND    ? a & b    :
           op == OP_OR     ? a | b    :
           op == OP_XOR    ? a ^ b    :
           op == OP_NOR    ? ~(a | b) :
           op == OP_ANDN   ? a & ~b   :
           op == OP_ORN    ? a | ~b   :
           op == OP_PASS_A ? a        : b;
  endfunction
endpackage

// File: rtl/logic_pipe_stage.sv
// logic_pipe_stage: one valid/payload register that advances when empty or when its downstream advances
module logic_pipe_stage
  import logic_unit_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         down_adv,
  output logic         adv,
  output logic         valid,
  output logic [W-1:0] data
);
  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;
  // advance when empty or draining; payload only loads when a real item arrives
  always_comb begin
    adv     = ~valid_q | down_adv;
    valid_d = adv ? up_valid : valid_q;
    data_d  = adv && up_valid ? up_data : data_q;
  end
  // stage register, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/logic_unit.sv
// logic_unit: pipelined eight-op bitwise unit with tag and valid/ready; LOGIC_UNIT_ZERO_FLAG_EN adds out_zero
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  localparam int ZW = 1;
`else
  localparam int ZW = 0;
`endif
  localparam int PW = WIDTH + TAG_W + ZW;
  logic [WIDTH-1:0]  res;
  logic [PW-1:0]     pay;
  logic [STAGES-1:0] v, adv;
  logic [PW-1:0]     d [STAGES];
  // bitwise result formed from the shared per-bit function
  always_comb begin
    res = '0;
    for (int i = 0; i < WIDTH; i++) res[i] = lu_compute_bit(op_t'(in_op), in_a[i], in_b[i]);
  end
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  assign pay = {~|res, in_tag, res};
`else
  assign pay = {in_tag, res};
`endif
  for (genvar s = 0; s < STAGES; s++) begin : g_st
    logic          up_v, dn;
    logic [PW-1:0] up_d;
    if (s == 0) begin : g_first
      assign up_v = in_valid;
      assign up_d = pay;
    end else begin : g_next
      assign up_v = v[s-1];
      assign up_d = d[s-1];
    end
    if (s == STAGES - 1) begin : g_last
      assign dn = out_ready;
    end else begin : g_inner
      assign dn = adv[s+1];
    end
    logic_pipe_stage #(.W(PW)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_v),
      .up_data  (up_d),
      .down_adv (dn),
      .adv      (adv[s]),
      .valid    (v[s]),
      .data     (d[s])
    );
  end
  assign in_ready   = adv[0];
  assign out_valid  = v[STAGES-1];
  assign out_result = d[STAGES-1][WIDTH-1:0];
  assign out_tag    = d[STAGES-1][WIDTH +: TAG_W];
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  assign out_zero   = d[STAGES-1][PW-1];
`endif
endmodule

// File: tb/tb_logic_unit.sv
// tb_logic_unit: vector table, hand sequences and random traffic against a queue-based reference model
module tb_logic_unit;
  localparam int W = 32;
  localparam int S = 2;
  localparam int T = 5;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   in_op = '0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [T-1:0] in_tag = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_result;
  logic [T-1:0] out_tag;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic         out_zero;
`endif
  int checks = 0;
  int failures = 0;
  typedef struct { logic [W-1:0] r; logic [T-1:0] t; } exp_t;
  exp_t q[$];
  typedef struct { logic [2:0] op; logic [W-1:0] a; logic [W-1:0] b; logic [T-1:0] tag; logic [W-1:0] exp; } vec_t;
  vec_t vt[8];

  logic_unit #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    ,
    .out_zero   (out_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return a;
      default: return b;
    endcase
  endfunction

  // scoreboard: FIFO of expected results, occupancy-derived in_ready
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      chk("in_ready_model", 64'(in_ready), 64'((q.size() < S) || out_ready));
      if (q.size() == 0) chk("idle_out_valid", 64'(out_valid), 64'(0));
      else if (out_valid) begin
        chk("sb_result", 64'(out_result), 64'(q[0].r));
        chk("sb_tag", 64'(out_tag), 64'(q[0].t));
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        chk("sb_zero", 64'(out_zero), 64'(q[0].r == '0));
`endif
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back('{ref_op(in_op, in_a, in_b), in_tag});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic v, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [T-1:0] tag);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag;
  endtask

  task automatic single_op(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [T-1:0] tag, logic [W-1:0] exp);
    set_in(1'b1, op, a, b, tag);
    @(negedge clk);
    chk("single_in_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < S; k++) begin
      @(negedge clk);
      chk("single_early_valid", 64'(out_valid), 64'(0));
      tick();
    end
    @(negedge clk);
    chk("single_valid", 64'(out_valid), 64'(1));
    chk("single_result", 64'(out_result), 64'(exp));
    chk("single_tag", 64'(out_tag), 64'(tag));
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    chk("single_zero", 64'(out_zero), 64'(exp == '0));
`endif
    tick();
  endtask

  task automatic drain(string n);
    int c;
    in_valid = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while ((q.size() != 0 || out_valid) && c < 50) begin
      tick();
      c++;
    end
    chk(n, 64'(q.size()), 64'(0));
  endtask

  initial begin
    logic [W-1:0] hr;
    logic [T-1:0] ht;
    int acc;
    vt[0] = '{3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd1, 32'h00F0_1234};
    vt[1] = '{3'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd2, 32'hFFF0_FFFF};
    vt[2] = '{3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd3, 32'hFF00_EDCB};
    vt[3] = '{3'd3, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd4, 32'h000F_0000};
    vt[4] = '{3'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd5, 32'hF000_0000};
    vt[5] = '{3'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd6, 32'hF0FF_1234};
    vt[6] = '{3'd6, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd7, 32'hF0F0_1234};
    vt[7] = '{3'd7, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd31, 32'h0FF0_FFFF};
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_result", 64'(out_result), 64'(0));
    chk("reset_out_tag", 64'(out_tag), 64'(0));
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    chk("reset_out_zero", 64'(out_zero), 64'(0));
`endif
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(in_ready), 64'(1));
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) single_op(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].exp);
    single_op(3'd2, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd9, 32'h0);
    single_op(3'd6, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd10, 32'hA5A5_A5A5);
    // back-to-back stream
    for (int i = 0; i < 8 + S; i++) begin
      if (i < 8) set_in(1'b1, 3'(i), $urandom, $urandom, 5'(i + 3));
      else in_valid = 1'b0;
      @(negedge clk);
      if (i < 8) chk("b2b_in_ready", 64'(in_ready), 64'(1));
      if (i >= S) begin
        chk("b2b_out_valid", 64'(out_valid), 64'(1));
        chk("b2b_out_tag", 64'(out_tag), 64'(i - S + 3));
      end
      tick();
    end
    // backpressure: exactly S accepts, stalled output stable
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < S + 4; i++) begin
      set_in(1'b1, 3'($urandom), $urandom, $urandom, 5'($urandom));
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    chk("bp_accepts", 64'(acc), 64'(S));
    hr = out_result;
    ht = out_tag;
    tick();
    tick();
    chk("bp_stable_result", 64'(out_result), 64'(hr));
    chk("bp_stable_tag", 64'(out_tag), 64'(ht));
    chk("bp_valid_held", 64'(out_valid), 64'(1));
    // full pipeline with simultaneous output transfer
    out_ready = 1'b1;
    set_in(1'b1, 3'd1, 32'h1234_0000, 32'h0000_5678, 5'd17);
    @(negedge clk);
    chk("simul_in_ready", 64'(in_ready), 64'(1));
    tick();
    out_ready = 1'b0;
    set_in(1'b1, 3'd0, $urandom, $urandom, 5'd18);
    @(negedge clk);
    chk("simul_still_full", 64'(in_ready), 64'(0));
    tick();
    drain("bp_drain_empty");
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom));
      if (i % 37 == 0) in_b = in_a;
      out_ready = ($urandom % 4) != 0;
      tick();
    end
    drain("rand_drain_empty");
    // asynchronous reset with two ops in flight
    set_in(1'b1, 3'd1, 32'hDEAD_0000, 32'h0000_BEEF, 5'd21);
    tick();
    set_in(1'b1, 3'd7, 32'h0, 32'h1111_2222, 5'd22);
    tick();
    in_valid = 1'b0;
    chk("pre_reset_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'(0));
    chk("async_reset_result", 64'(out_result), 64'(0));
    chk("async_reset_tag", 64'(out_tag), 64'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_valid", 64'(out_valid), 64'(0));
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/logic_unit.md
# logic_unit

Parametrised, pipelined bitwise logic unit for the ALU datapath. It supersedes the fixed 32-bit single-function AND/OR gates with one block that does the following:
- selects among eight bitwise operations at run time;
- carries a destination tag;
- moves operands through a configurable-depth register pipeline with valid/ready flow control, so the ALU can stall it.

## Interface
Parameters:
- WIDTH, 32: operand and result width in bits (≥1).
- STAGES, 2: pipeline register stages (≥1); latency when not stalled.
- TAG_W, 5: width of the sideband tag carried with each operation (e.g. destination register).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operation presented.
- in_ready, output, 1: block accepts the operation this cycle.
- in_op, input, 3: operation select (see Operation).
- in_a, input, WIDTH: operand A.
- in_b, input, WIDTH: operand B.
- in_tag, input, TAG_W: sideband tag.
- out_valid, output, 1: result presented.
- out_ready, input, 1: consumer accepts the result.
- out_result, output, WIDTH: result.
- out_tag, output, TAG_W: tag of the result.
- out_zero, output, 1: result is all zeros (only when LOGIC_UNIT_ZERO_FLAG_EN is defined).

## Operation
- Op encoding:
  - 000 AND (a&b)
  - 001 OR (a|b)
  - 010 XOR (a^b)
  - 011 NOR ~(a|b)
  - 100 ANDN (a&~b)
  - 101 ORN (a|~b)
  - 110 PASS_A
  - 111 PASS_B
- Result is computed combinationally from in_a/in_b/in_op and captured into stage 0 together with in_tag. Stages 1..STAGES-1 only delay the result.
- Each stage holds a valid bit, the result, and the tag.
- Stage i advances when it is empty or stage i+1 advances. The last stage advances when out_ready is high.
- in_ready = stage 0 advances (empty or draining). Bubbles collapse: a full upstream stage may move into an empty downstream stage even while the output is stalled.
- Transfer on input: in_valid & in_ready. Transfer on output: out_valid & out_ready.
- out_valid, out_result, out_tag and out_zero come directly from the last stage's registers; there is no combinational input-to-output path.
- Ordering is strictly FIFO. No operation is dropped or duplicated.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits clear, data and tags clear. Outputs are out_valid=0, out_result=0, out_tag=0, out_zero=0. in_ready=1 from the first cycle after rst_n rises.
- Reset asserted mid-operation discards all in-flight operations.
- Latency: an operation accepted in cycle N appears with out_valid=1 in cycle N+STAGES if it is not stalled.
- Throughput: one operation per cycle when out_ready is held high.
- Stall: while out_valid=1 and out_ready=0, the last stage holds its result and tag stable. in_ready drops only once every stage is full.
- Full pipeline with simultaneous output transfer: in_ready=1 in the same cycle, and an input is accepted.
- in_op values are all defined; there is no illegal-op state.

## Configuration
- LOGIC_UNIT_ZERO_FLAG_EN defined:
  - stage 0 also registers zero = ~|result, and the flag is carried through the stages;
  - out_zero is a port, valid whenever out_valid=1, and reset to 0.
- LOGIC_UNIT_ZERO_FLAG_EN undefined: the out_zero port and its flag registers are absent.

## Structure
- Shared package logic_unit_pkg:
  - 3-bit op typedef and the eight op constants;
  - the result-compute function, which is reused by the ALU decoder checks.
- Sub-module logic_pipe_stage: one valid/data/tag register with its advance logic, parameterised by payload width. logic_unit instantiates STAGES of them in a generate loop.

## Test plan
- Reset then single ops (defaults), with out_ready=1:
  - a=0xF0F0_1234, b=0x0FF0_FFFF, op=AND gives 0x00F0_1234 two cycles after acceptance, with its tag.
  - The same a and b give OR 0xFFF0_FFFF, XOR 0xFF00_EDCB, NOR 0x000F_0000.
- Back-to-back: 8 ops on consecutive cycles with out_ready=1 give 8 results on consecutive cycles, in order, with matching tags. in_ready stays 1 throughout.
- Backpressure: hold out_ready=0 and stream inputs.
  - in_ready drops after exactly STAGES accepts, and out_result stays stable.
  - Releasing out_ready drains everything in order, with no loss.
- Simultaneous: pipeline full and out_ready=1 in the same cycle as in_valid=1. The input is accepted and occupancy stays full.
- Zero flag (macro defined): a=b=0xA5A5_A5A5, op=XOR gives out_zero=1. op=PASS_A gives out_zero=0.
- Asynchronous reset mid-stream with 2 ops in flight: out_valid goes 0 immediately, and no stale result appears after reset is released.
